reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised, multi-read-port integer register file with two write ports (ALU writeback, memory-load writeback) and a per-register busy scoreboard.
- Successor to the single-port-pair file in the core's decode/writeback path.
- Adds configurable width, depth and read-port count, a hardwired zero register, deterministic write-port priority, and load-use hazard tracking for the issue stage.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- ADDR_W, $clog2(NREGS), register address width; derived, must not be overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*XLEN  packed read data, combinational from rd_addr.
- rd_busy  out  NRD  busy bit of the register addressed by each read port, combinational.
- wa_en  in  1  ALU writeback enable.
- wa_addr  in  ADDR_W  ALU writeback register.
- wa_data  in  XLEN  ALU writeback data.
- wm_en  in  1  load writeback enable.
- wm_addr  in  ADDR_W  load writeback register.
- wm_data  in  XLEN  load writeback data.
- iss_en  in  1  a load has issued; mark its destination busy.
- iss_addr  in  ADDR_W  destination register of the issued load.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- collide  out  1  registered; 1 for one cycle after wa and wm wrote the same non-zero register.

Behaviour:
- Reset (asynchronous): all registers = 0, all busy bits = 0, collide = 0. Every register is cleared, not only register 0.
- Register 0:
  - reads always return 0 and never report busy;
  - writes and issues targeting it are ignored.
- Writes: committed on the rising clock edge; one-cycle write latency.
  - When wa and wm target the same register, wm_data is stored, and collide is set at the same edge.
  - Writes to different registers both commit.
- Reads: purely combinational, with no read latency.
- Scoreboard, per register r (non-zero), next busy[r] by priority:
  1. flush: 0.
  2. iss_en and iss_addr == r: 1. A new producer overrides a same-cycle clear.
  3. wm_en and wm_addr == r: 0.
  4. Otherwise: hold.
- wa writes never clear busy bits.
- flush does not block same-cycle data writes.
- flush together with iss_en: flush wins, and the issued register is not marked busy.
- Reset asserted mid-operation: the state machine is dropped immediately; the first edge after deassertion behaves as from power-up.

Optional Feature:
- REG_FILE_BYPASS_EN defined:
  - rd_data forwards same-cycle write data (wm over wa on address match, never for register 0);
  - rd_busy reports 0 for a register being written by wm in that cycle, unless it is also being issued.
- Undefined: reads return the pre-edge stored value, and rd_busy reflects the stored busy bit only.

Decomposition:
- Package reg_file_pkg holds:
  - default XLEN/NREGS constants;
  - the ZERO_REG constant (0);
  - typedef reg_addr_t (logic [ADDR_W-1:0] for the default depth);
  - typedef xword_t (logic [XLEN-1:0]).
- One natural sub-module, reg_scoreboard: the busy-bit vector, its update priority, and the busy read muxes.
- Storage, write arbitration and the bypass logic stay in reg_file_sb.

Test Plan:
- Reset, then read x0..x31 on every port:
  - all reads = 0 and rd_busy = 0;
  - wa_en with wa_addr = 0 and wa_data = 0xDEADBEEF, next cycle read 0: returns 0.
- wa writes x5 = 0x12345678; following cycle, rd_addr port0 = 5 and port1 = 5: both ports show 0x12345678.
- wa writes x7 = 0x11 and wm writes x7 = 0x22 in the same cycle:
  - next cycle x7 reads 0x22 and collide = 1 for exactly one cycle;
  - the same collision on x0 leaves collide = 0.
- iss_en with iss_addr = 9:
  - next cycle rd_busy = 1 for x9;
  - wm writes x9 = 0x55: busy clears the following cycle and x9 reads 0x55;
  - iss_en on x9 together with wm to x9: busy stays 1.
- Mark x3, x4 busy, then pulse flush with iss_en on x6: all busy bits read 0 afterwards.
- Same-cycle wm write x10 = 0xA5 with a read of x10:
  - with REG_FILE_BYPASS_EN, rd_data = 0xA5 in that cycle;
  - without it, rd_data shows the old value;
  - assert reset in the middle of the sequence: all outputs return to 0 immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the integer register file.
// Holds the default geometry, the hardwired zero-register index and the
// default-width address/data types used by the file and its scoreboard.
package reg_file_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

    // Register x0 reads as zero, is never busy and ignores writes/issues.
    localparam int ZERO_REG   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   xword_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register busy bits for load-use hazard tracking.
// A load issue marks its destination busy, the load writeback clears it,
// and a pipeline flush clears everything. Register 0 is never busy.
// Busy read muxes here return the stored bit only; same-cycle forwarding
// of a clearing writeback is applied by the parent when enabled.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  wm_en,
    input  logic [ADDR_W-1:0]     wm_addr,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy vector: flush, then new producer, then load writeback, else hold.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (r == ZERO_REG) begin
                busy_d[r] = 1'b0;
            end else if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_en && (iss_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wm_en && (wm_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Busy state register; cleared asynchronously on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port busy lookup of the stored bit.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port integer register file with ALU and load
// writeback ports and a busy scoreboard for load-use hazards.
// Register 0 is hardwired to zero. When both writeback ports hit the same
// register in one cycle the load data wins and collide pulses next cycle.
// Optional build macro REG_FILE_BYPASS_EN: reads forward same-cycle write
// data (load over ALU) and a register being written back by a load reads
// as not busy unless it is issued again in the same cycle.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wm_en,
    input  logic [ADDR_W-1:0]     wm_addr,
    input  logic [XLEN-1:0]       wm_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush,
    output logic                  collide
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            collide_q;
    logic            wa_live;
    logic            wm_live;
    logic [NRD-1:0]  sb_busy;

    assign wa_live = wa_en && (wa_addr != ZERO_A);
    assign wm_live = wm_en && (wm_addr != ZERO_A);

    // Storage: ALU write first, load write second so the load wins a tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (wa_live) begin
                regs_q[wa_addr] <= wa_data;
            end
            if (wm_live) begin
                regs_q[wm_addr] <= wm_data;
            end
        end
    end

    // Collision flag: both ports wrote the same non-zero register last cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            collide_q <= 1'b0;
        end else begin
            collide_q <= wa_live && wm_live && (wa_addr == wm_addr);
        end
    end

    assign collide = collide_q;

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wm_en    (wm_en),
        .wm_addr  (wm_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
        logic              busy;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        // Read data mux, optionally forwarding this cycle's writeback.
        always_comb begin
            data = regs_q[addr];
`ifdef REG_FILE_BYPASS_EN
            if (wa_live && (wa_addr == addr)) begin
                data = wa_data;
            end
            if (wm_live && (wm_addr == addr)) begin
                data = wm_data;
            end
`endif
            if (addr == ZERO_A) begin
                data = '0;
            end
        end

        // Busy report, optionally hiding a load writeback landing this cycle.
        always_comb begin
            busy = sb_busy[i];
`ifdef REG_FILE_BYPASS_EN
            if (wm_live && (wm_addr == addr) && !(iss_en && (iss_addr == addr))) begin
                busy = 1'b0;
            end
`endif
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: self-checking bench for reg_file_sb with a behavioural
// model; expectations are queued when reads are set up and popped once the
// combinational outputs have settled.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clock;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wa_en;
    logic [AW-1:0]        wa_addr;
    logic [XLEN-1:0]      wa_data;
    logic                 wm_en;
    logic [AW-1:0]        wm_addr;
    logic [XLEN-1:0]      wm_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 flush;
    logic                 collide;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wm_en    (wm_en),
        .wm_addr  (wm_addr),
        .wm_data  (wm_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .collide  (collide)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          kind;   // 0 data, 1 busy, 2 collide
        int          port;
        int          addr;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    string kn[3] = '{"data", "busy", "collide"};

    logic [31:0] mdl_regs [NREGS];
    logic        mdl_busy [NREGS];
    logic        mdl_collide;

    task automatic mdl_clear();
        for (int r = 0; r < NREGS; r++) begin
            mdl_regs[r] = '0;
            mdl_busy[r] = 1'b0;
        end
        mdl_collide = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input int a);
        if (a == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (wm_en && wm_addr == 5'(a)) return wm_data;
        if (wa_en && wa_addr == 5'(a)) return wa_data;
`endif
        return mdl_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
        if (wm_en && wm_addr == 5'(a) && !(iss_en && iss_addr == 5'(a))) return 1'b0;
`endif
        return mdl_busy[a];
    endfunction

    // One clock edge, with the model advanced from the inputs held before it.
    task automatic tick();
        logic [31:0] nr [NREGS];
        logic        nb [NREGS];
        logic        nc;
        nr = mdl_regs;
        nb = mdl_busy;
        if (wa_en && wa_addr != 5'd0) nr[wa_addr] = wa_data;
        if (wm_en && wm_addr != 5'd0) nr[wm_addr] = wm_data;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) nb[r] = 1'b0;
            else if (iss_en && iss_addr == 5'(r)) nb[r] = 1'b1;
            else if (wm_en && wm_addr == 5'(r)) nb[r] = 1'b0;
        end
        nc = wa_en && wm_en && (wa_addr == wm_addr) && (wa_addr != 5'd0);
        @(posedge clock);
        mdl_regs    = nr;
        mdl_busy    = nb;
        mdl_collide = nc;
        #1;
    endtask

    task automatic idle();
        wa_en  = 1'b0;
        wm_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    // Point both read ports and queue what the model says they must show.
    task automatic push_reads(input int a0, input int a1);
        exp_t e;
        rd_addr = {5'(a1), 5'(a0)};
        for (int p = 0; p < NRD; p++) begin
            e.port = p;
            e.addr = (p == 0) ? a0 : a1;
            e.kind = 0; e.val = exp_data(e.addr);          exp_q.push_back(e);
            e.kind = 1; e.val = {31'b0, exp_busy(e.addr)}; exp_q.push_back(e);
        end
        e.port = 0; e.addr = 0; e.kind = 2; e.val = {31'b0, mdl_collide};
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] got;
        idle();
        wa_addr = '0; wa_data = '0; wm_addr = '0; wm_data = '0; iss_addr = '0;
        rd_addr = '0;
        reset = 1'b1;
        mdl_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int a = 0; a < NREGS; a++) begin
            push_reads(a, NREGS - 1 - a);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       got = rd_data[e.port*XLEN +: XLEN];
                    1:       got = {31'b0, rd_busy[e.port]};
                    default: got = {31'b0, collide};
                endcase
                total++;
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL reset_%s port=%0d addr=%0d got=%h exp=%h", kn[e.kind], e.port, e.addr, got, e.val);
                end
            end
        end
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEADBEEF;
        tick();
        idle();
        push_reads(0, 0);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       got = rd_data[e.port*XLEN +: XLEN];
                1:       got = {31'b0, rd_busy[e.port]};
                default: got = {31'b0, collide};
            endcase
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL x0_write_%s port=%0d addr=%0d got=%h exp=%h", kn[e.kind], e.port, e.addr, got, e.val);
            end
        end
    endtask

    task automatic test_alu_write();
        exp_t e;
        logic [31:0] got;
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h12345678;
        tick();
        idle();
        push_reads(5, 5);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       got = rd_data[e.port*XLEN +: XLEN];
                1:       got = {31'b0, rd_busy[e.port]};
                default: got = {31'b0, collide};
            endcase
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL alu_write_%s port=%0d addr=%0d got=%h exp=%h", kn[e.kind], e.port, e.addr, got, e.val);
            end
        end
        wa_en = 1'b1; wa_addr = 5'd11; wa_data = 32'hCAFE0001;
        wm_en = 1'b1; wm_addr = 5'd12; wm_data = 32'hBEEF0002;
        tick();
        idle();
        push_reads(11, 12);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       got = rd_data[e.port*XLEN +: XLEN];
                1:       got = {31'b0, rd_busy[e.port]};
                default: got = {31'b0, collide};
            endcase
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL dual_write_%s port=%0d addr=%0d got=%h exp=%h", kn[e.kind], e.port, e.addr, got, e.val);
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        logic [31:0] got;
        for (int step = 0; step < 3; step++) begin
            if (step == 0) begin
                wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
                wm_en = 1'b1; wm_addr = 5'd7; wm_data = 32'h22;
            end else if (step == 2) begin
                wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h33;
                wm_en = 1'b1; wm_addr = 5'd0; wm_data = 32'h44;
            end
            tick();
            idle();
            push_reads(7, 0);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       got = rd_data[e.port*XLEN +: XLEN];
                    1:       got = {31'b0, rd_busy[e.port]};
                    default: got = {31'b0, collide};
                endcase
                total++;
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL collision%0d_%s port=%0d addr=%0d got=%h exp=%h", step, kn[e.kind], e.port, e.addr, got, e.val);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [31:0] got;
        for (int step = 0; step < 6; step++) begin
            case (step)
                0: begin iss_en = 1'b1; iss_addr = 5'd9; end
                1: begin wm_en = 1'b1; wm_addr = 5'd9; wm_data = 32'h55; end
                2: begin
                    iss_en = 1'b1; iss_addr = 5'd9;
                    wm_en = 1'b1; wm_addr = 5'd9; wm_data = 32'h66;
                end
                3: begin wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h77; end
                4: begin iss_en = 1'b1; iss_addr = 5'd0; end
                default: begin wm_en = 1'b1; wm_addr = 5'd9; wm_data = 32'h88; end
            endcase
            tick();
            idle();
            push_reads(9, 0);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       got = rd_data[e.port*XLEN +: XLEN];
                    1:       got = {31'b0, rd_busy[e.port]};
                    default: got = {31'b0, collide};
                endcase
                total++;
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL scoreboard%0d_%s port=%0d addr=%0d got=%h exp=%h", step, kn[e.kind], e.port, e.addr, got, e.val);
                end
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [31:0] got;
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd4;
        tick();
        idle();
        push_reads(3, 4);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       got = rd_data[e.port*XLEN +: XLEN];
                1:       got = {31'b0, rd_busy[e.port]};
                default: got = {31'b0, collide};
            endcase
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL pre_flush_%s port=%0d addr=%0d got=%h exp=%h", kn[e.kind], e.port, e.addr, got, e.val);
            end
        end
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wa_en = 1'b1; wa_addr = 5'd13; wa_data = 32'h1313;
        tick();
        idle();
        for (int a = 1; a < NREGS; a++) begin
            push_reads(a, a);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       got = rd_data[e.port*XLEN +: XLEN];
                    1:       got = {31'b0, rd_busy[e.port]};
                    default: got = {31'b0, collide};
                endcase
                total++;
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL flush_%s port=%0d addr=%0d got=%h exp=%h", kn[e.kind], e.port, e.addr, got, e.val);
                end
            end
        end
    endtask

    task automatic test_bypass_and_reset();
        exp_t e;
        logic [31:0] got;
        for (int step = 0; step < 6; step++) begin
            case (step)
                0: begin
                    iss_en = 1'b1; iss_addr = 5'd10;
                    tick();
                    idle();
                end
                1: begin
                    // same-cycle writes observed before the edge
                    wm_en = 1'b1; wm_addr = 5'd10; wm_data = 32'hA5;
                    wa_en = 1'b1; wa_addr = 5'd14; wa_data = 32'h1414;
                end
                2: begin
                    tick();
                    idle();
                end
                3: begin
                    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h1;
                    wm_en = 1'b1; wm_addr = 5'd10; wm_data = 32'h2;
                    iss_en = 1'b1; iss_addr = 5'd14;
                    tick();
                    idle();
                end
                4: begin
                    #1;
                    reset = 1'b1;
                    mdl_clear();
                end
                default: begin
                    reset = 1'b0;
                    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h99;
                    tick();
                    idle();
                end
            endcase
            push_reads(10, 14);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       got = rd_data[e.port*XLEN +: XLEN];
                    1:       got = {31'b0, rd_busy[e.port]};
                    default: got = {31'b0, collide};
                endcase
                total++;
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL bypass_reset%0d_%s port=%0d addr=%0d got=%h exp=%h", step, kn[e.kind], e.port, e.addr, got, e.val);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_alu_write();
        test_collision();
        test_scoreboard();
        test_flush();
        test_bypass_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
